// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, with a 2-FF input synchronizer and mid-bit sampling.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and enables the rx_parity_err pulse.
module uart_rx #(
   parameter int clk_freq = 12_000_000,
   parameter int baud     = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       rx_frame_err,
   output logic       rx_parity_err
);

   localparam int DIV  = clk_freq / baud;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);

   localparam logic [CW-1:0] C_DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   logic          w_rx_s;
   state_t        r_state;
   logic [CW-1:0] r_bit_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_ferr;
`ifdef UART_RX_PARITY_EN
   logic          r_par;
   logic          r_perr;
`endif

   // NOTE: every clocked assignment uses <= so all flops sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx_s = r_sync2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par     <= 1'b0;
         r_perr    <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr  <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               r_bit_cnt <= '0;
               if (!w_rx_s) r_state <= S_START;
            end

            // A start bit that is high again by mid-bit was a glitch: drop it silently.
            S_START: begin
               if (r_bit_cnt == C_HALF_M1) begin
                  r_bit_cnt <= '0;
                  if (!w_rx_s) begin
                     r_state   <= S_DATA;
                     r_bit_idx <= '0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end

            S_DATA: begin
               if (r_bit_cnt == C_DIV_M1) begin
                  r_bit_cnt <= '0;
                  r_shift   <= {w_rx_s, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (r_bit_cnt == C_DIV_M1) begin
                  r_bit_cnt <= '0;
                  r_par     <= w_rx_s;
                  r_state   <= S_STOP;
               end else begin
                  r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end
`endif

            // Leaving at mid-stop lets the next start edge be seen without a gap.
            S_STOP: begin
               if (r_bit_cnt == C_DIV_M1) begin
                  r_bit_cnt <= '0;
                  if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                     if (^{r_shift, r_par}) begin
                        r_perr <= 1'b1;
                     end else begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end
`else
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
`endif
                     r_state <= S_IDLE;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= S_BREAK;
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end

            // A held-low line reports one framing error, then waits for the line to idle.
            S_BREAK: begin
               r_bit_cnt <= '0;
               if (w_rx_s) r_state <= S_IDLE;
            end

            default: begin
               r_bit_cnt <= '0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign rx_data      = r_data;
   assign rx_valid     = r_valid;
   assign rx_busy      = (r_state != S_IDLE);
   assign rx_frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
   assign rx_parity_err = r_perr;
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx; one receiver at the default 1250 cycles/bit,
// a second at 312 cycles/bit for the longer scenarios. Expected timing comes from DIV/HALF.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int S_DIV  = 12_000_000 / 9600;     // 1250
   localparam int S_HALF = S_DIV / 2;             // 625
   localparam int F_BAUD = 38_400;
   localparam int F_DIV  = 12_000_000 / F_BAUD;   // 312
   localparam int F_HALF = F_DIV / 2;             // 156
`ifdef UART_RX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   // Pin falling edge to valid pulse: 3 sync/entry cycles + half bit + 9 (or 10) bit times.
   localparam int S_T_VALID = 3 + S_HALF + (9 + PBITS) * S_DIV;   // 11878 in 8N1
   localparam int F_T_VALID = 3 + F_HALF + (9 + PBITS) * F_DIV;
   localparam int F_FRAME   = (10 + PBITS) * F_DIV;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] s_data, f_data;
   logic       s_valid, s_busy, s_ferr, s_perr;
   logic       f_valid, f_busy, f_ferr, f_perr;

   always #5 clk = ~clk;

   uart_rx #(.clk_freq(12_000_000), .baud(9600)) dut_slow (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .rx_data      (s_data),
      .rx_valid     (s_valid),
      .rx_busy      (s_busy),
      .rx_frame_err (s_ferr),
      .rx_parity_err(s_perr)
   );

   uart_rx #(.clk_freq(12_000_000), .baud(F_BAUD)) dut_fast (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .rx_data      (f_data),
      .rx_valid     (f_valid),
      .rx_busy      (f_busy),
      .rx_frame_err (f_ferr),
      .rx_parity_err(f_perr)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event log, written only here; scenarios compare against snapshots.
   int         f_vcnt = 0, f_fcnt = 0, f_pcnt = 0, f_both = 0, f_fcyc = 0, f_pcyc = 0;
   int         s_vcnt = 0, s_fcnt = 0, s_vcyc = 0;
   logic [7:0] s_vdat = 8'h00;
   int         f_vcyc[$];
   logic [7:0] f_vdat[$];
   int         f_brise[$], f_bfall[$], s_brise[$], s_bfall[$];
   logic       f_busy_q = 1'b0, s_busy_q = 1'b0;

   always @(negedge clk) begin
      if (f_valid === 1'b1) begin
         f_vcnt++;
         f_vcyc.push_back(cyc);
         f_vdat.push_back(f_data);
      end
      if (f_ferr === 1'b1) begin
         f_fcnt++;
         f_fcyc = cyc;
      end
      if (f_perr === 1'b1) begin
         f_pcnt++;
         f_pcyc = cyc;
      end
      if (f_valid === 1'b1 && f_ferr === 1'b1) f_both++;
      if (s_valid === 1'b1) begin
         s_vcnt++;
         s_vcyc = cyc;
         s_vdat = s_data;
      end
      if (s_ferr === 1'b1) s_fcnt++;
      if (f_busy === 1'b1 && !f_busy_q) f_brise.push_back(cyc);
      if (f_busy === 1'b0 &&  f_busy_q) f_bfall.push_back(cyc);
      if (s_busy === 1'b1 && !s_busy_q) s_brise.push_back(cyc);
      if (s_busy === 1'b0 &&  s_busy_q) s_bfall.push_back(cyc);
      f_busy_q = (f_busy === 1'b1);
      s_busy_q = (s_busy === 1'b1);
   end

   int checks = 0;
   int errors = 0;
   int t_start = 0;

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int div);
      t_start = cyc;
      hold(1'b0, div);
      for (int i = 0; i < 8; i++) hold(d[i], div);
`ifdef UART_RX_PARITY_EN
      hold(par, div);
`else
      if (par === 1'bx) rx = 1'b1;
`endif
      hold(stop, div);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (f_data !== 8'h00) begin
         errors++; $display("FAIL reset_f_data: got %h want 00", f_data);
      end
      checks++;
      if ({f_valid, f_busy, f_ferr, f_perr} !== 4'b0000) begin
         errors++; $display("FAIL reset_f_flags: got %b want 0000", {f_valid, f_busy, f_ferr, f_perr});
      end
      checks++;
      if (s_data !== 8'h00) begin
         errors++; $display("FAIL reset_s_data: got %h want 00", s_data);
      end
      checks++;
      if ({s_valid, s_busy, s_ferr, s_perr} !== 4'b0000) begin
         errors++; $display("FAIL reset_s_flags: got %b want 0000", {s_valid, s_busy, s_ferr, s_perr});
      end
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if ({f_busy, s_busy} !== 2'b00) begin
         errors++; $display("FAIL reset_idle_busy: got %b want 00", {f_busy, s_busy});
      end
   endtask

   task automatic test_single();
      int v0 = s_vcnt;
      int f0 = s_fcnt;
      int r0 = s_brise.size();
      int b0 = s_bfall.size();
      int rise, fall;
      send_frame(8'h41, 1'b0, 1'b1, S_DIV);
      checks++;
      if (s_vcnt - v0 != 1) begin
         errors++; $display("FAIL single_valid_count: got %0d want 1", s_vcnt - v0);
      end
      checks++;
      if (s_vcyc - t_start != S_T_VALID) begin
         errors++; $display("FAIL single_valid_cycle: got %0d want %0d", s_vcyc - t_start, S_T_VALID);
      end
      checks++;
      if (s_vdat !== 8'h41) begin
         errors++; $display("FAIL single_data: got %h want 41", s_vdat);
      end
      checks++;
      if (s_fcnt != f0) begin
         errors++; $display("FAIL single_frame_err: got %0d want 0", s_fcnt - f0);
      end
      rise = (s_brise.size() > r0) ? s_brise[r0] - t_start : -1;
      fall = (s_bfall.size() > b0) ? s_bfall[b0] - t_start : -1;
      checks++;
      if (rise != 3) begin
         errors++; $display("FAIL single_busy_rise: got %0d want 3", rise);
      end
      checks++;
      if (fall != S_T_VALID && fall != S_T_VALID + 1) begin
         errors++; $display("FAIL single_busy_fall: got %0d want %0d", fall, S_T_VALID);
      end
      // Let the fast receiver finish whatever it made of the slow frame.
      hold(1'b1, 12 * F_DIV);
   endtask

   task automatic test_glitch();
      int v0 = f_vcnt;
      int f0 = f_fcnt;
      int r0 = f_brise.size();
      int b0 = f_bfall.size();
      int t0 = cyc;
      int rise, fall;
      hold(1'b0, 75);
      hold(1'b1, 2 * F_DIV);
      rise = (f_brise.size() > r0) ? f_brise[r0] - t0 : -1;
      fall = (f_bfall.size() > b0) ? f_bfall[b0] - t0 : -1;
      checks++;
      if (rise != 3) begin
         errors++; $display("FAIL glitch_busy_rise: got %0d want 3", rise);
      end
      checks++;
      if (fall != 3 + F_HALF) begin
         errors++; $display("FAIL glitch_idle_return: got %0d want %0d", fall, 3 + F_HALF);
      end
      checks++;
      if (f_vcnt != v0 || f_fcnt != f0) begin
         errors++; $display("FAIL glitch_pulses: got valid=%0d ferr=%0d want 0 0", f_vcnt - v0, f_fcnt - f0);
      end
   endtask

   task automatic test_frame_err();
      int v0 = f_vcnt;
      int v1, f1, t42;
      send_frame(8'h41, 1'b0, 1'b1, F_DIV);
      checks++;
      if (f_vcnt - v0 != 1 || f_data !== 8'h41) begin
         errors++; $display("FAIL ferr_pre_byte: got n=%0d data=%h want 1 41", f_vcnt - v0, f_data);
      end
      v1 = f_vcnt;
      f1 = f_fcnt;
      send_frame(8'h42, ^8'h42, 1'b0, F_DIV);
      t42 = t_start;
      hold(1'b0, 5 * F_DIV);
      hold(1'b1, 2 * F_DIV);
      checks++;
      if (f_fcnt - f1 != 1) begin
         errors++; $display("FAIL ferr_count: got %0d want 1", f_fcnt - f1);
      end
      checks++;
      if (f_fcyc - t42 != F_T_VALID) begin
         errors++; $display("FAIL ferr_cycle: got %0d want %0d", f_fcyc - t42, F_T_VALID);
      end
      checks++;
      if (f_vcnt != v1 || f_data !== 8'h41) begin
         errors++; $display("FAIL ferr_data_hold: got n=%0d data=%h want 0 41", f_vcnt - v1, f_data);
      end
      send_frame(8'h43, ^8'h43, 1'b1, F_DIV);
      checks++;
      if (f_vcnt - v1 != 1 || f_data !== 8'h43 || f_fcnt - f1 != 1) begin
         errors++; $display("FAIL ferr_recover: got n=%0d data=%h ferr=%0d want 1 43 1", f_vcnt - v1, f_data, f_fcnt - f1);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_d [3] = '{8'h00, 8'hFF, 8'h55};
      int v0 = f_vcnt;
      int b  = f_vcyc.size();
      int f0 = f_fcnt;
      int p0 = f_pcnt;
      for (int i = 0; i < 3; i++) send_frame(exp_d[i], ^exp_d[i], 1'b1, F_DIV);
      hold(1'b1, F_DIV);
      checks++;
      if (f_vcnt - v0 != 3) begin
         errors++; $display("FAIL b2b_count: got %0d want 3", f_vcnt - v0);
      end
      if (f_vcyc.size() >= b + 3) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (f_vdat[b+i] !== exp_d[i]) begin
               errors++; $display("FAIL b2b_data%0d: got %h want %h", i, f_vdat[b+i], exp_d[i]);
            end
         end
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (f_vcyc[b+i] - f_vcyc[b+i-1] != F_FRAME) begin
               errors++; $display("FAIL b2b_spacing%0d: got %0d want %0d", i, f_vcyc[b+i] - f_vcyc[b+i-1], F_FRAME);
            end
         end
      end
      checks++;
      if (f_fcnt != f0 || f_pcnt != p0) begin
         errors++; $display("FAIL b2b_errors: got ferr=%0d perr=%0d want 0 0", f_fcnt - f0, f_pcnt - p0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d = 8'h5A;
      int v0 = f_vcnt;
      int f0 = f_fcnt;
      int p0 = f_pcnt;
      hold(1'b0, F_DIV);
      for (int i = 0; i < 4; i++) hold(d[i], F_DIV);
      hold(d[4], F_DIV / 2);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({f_data, f_valid, f_busy, f_ferr, f_perr} !== 12'h000) begin
         errors++; $display("FAIL rstmid_outputs: got data=%h flags=%b want 00 0000", f_data, {f_valid, f_busy, f_ferr, f_perr});
      end
      rst_n = 1'b1;
      hold(1'b1, 12 * F_DIV);
      checks++;
      if (f_vcnt != v0 || f_fcnt != f0 || f_pcnt != p0 || f_busy !== 1'b0) begin
         errors++; $display("FAIL rstmid_quiet: got v=%0d f=%0d p=%0d busy=%b want 0 0 0 0", f_vcnt - v0, f_fcnt - f0, f_pcnt - p0, f_busy);
      end
      send_frame(8'h5A, ^8'h5A, 1'b1, F_DIV);
      checks++;
      if (f_vcnt - v0 != 1 || f_data !== 8'h5A) begin
         errors++; $display("FAIL rstmid_next_frame: got n=%0d data=%h want 1 5a", f_vcnt - v0, f_data);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int v0 = f_vcnt;
      int p0 = f_pcnt;
      send_frame(8'h41, 1'b0, 1'b1, F_DIV);
      checks++;
      if (f_vcnt - v0 != 1 || f_data !== 8'h41 || f_pcnt != p0) begin
         errors++; $display("FAIL parity_good: got n=%0d data=%h perr=%0d want 1 41 0", f_vcnt - v0, f_data, f_pcnt - p0);
      end
      v0 = f_vcnt;
      send_frame(8'h41, 1'b1, 1'b1, F_DIV);
      checks++;
      if (f_pcnt - p0 != 1 || f_vcnt != v0) begin
         errors++; $display("FAIL parity_bad: got perr=%0d valid=%0d want 1 0", f_pcnt - p0, f_vcnt - v0);
      end
      checks++;
      if (f_pcyc - t_start != F_T_VALID) begin
         errors++; $display("FAIL parity_cycle: got %0d want %0d", f_pcyc - t_start, F_T_VALID);
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      checks++;
      if (f_both != 0) begin
         errors++; $display("FAIL valid_ferr_overlap: got %0d want 0", f_both);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
